// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter feeding one byte per frame to a UART transmitter.
// Round-robin with per-requester lock, start-handshake timeout and a drain phase.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [1:0]  req_valid_i,
  input  logic [15:0] req_data_i,
  input  logic [1:0]  req_lock_i,
  output logic [1:0]  req_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  input  logic        tx_clear_i,
  input  logic        tx_busy_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, START, DRAIN} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] count;
  logic        last;
  logic        owner_lock;
  logic [1:0]  pick;
  logic        sel_idx;

  // A locked owner is the only candidate; otherwise the requester not served last wins.
  always_comb begin
    owner_lock = |(grant_o & req_lock_i);
    pick       = 2'b00;
    if (owner_lock) begin
      pick = grant_o & req_valid_i;
    end else if (last) begin
      pick = req_valid_i[0] ? 2'b01 : (req_valid_i[1] ? 2'b10 : 2'b00);
    end else begin
      pick = req_valid_i[1] ? 2'b10 : (req_valid_i[0] ? 2'b01 : 2'b00);
    end
    sel_idx = pick[1];
  end

  // Ready must coincide with the capture edge, so it is decoded rather than registered.
  assign req_ready_o = (state == IDLE && !wb_rst_i) ? pick : 2'b00;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      tx_start_o <= 1'b0;
      tx_data_o  <= 8'h00;
      grant_o    <= 2'b00;
      timeout_o  <= 1'b0;
      count      <= 16'd0;
      last       <= 1'b1;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pick != 2'b00) begin
            tx_data_o  <= sel_idx ? req_data_i[15:8] : req_data_i[7:0];
            grant_o    <= pick;
            last       <= sel_idx;
            count      <= 16'd0;
            tx_start_o <= 1'b1;
            state      <= START;
          end else if (!owner_lock) begin
            grant_o <= 2'b00;
          end
        end
        START: begin
          // A clear arriving on the final allowed cycle still wins over the timeout.
          if (tx_clear_i) begin
            tx_start_o <= 1'b0;
            state      <= DRAIN;
          end else if (count == TIMEOUT_LAST) begin
            tx_start_o <= 1'b0;
            timeout_o  <= 1'b1;
            grant_o    <= 2'b00;
            state      <= IDLE;
          end else begin
            count <= count + 16'd1;
          end
        end
        DRAIN: begin
          if (!tx_busy_i) begin
            state <= IDLE;
            if (!owner_lock) grant_o <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535: max cycles tx_start_o is held waiting for tx_clear_i (range 1..65535).
REQ-002 SHALL have port wb_clk_i  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid_i  input  2  per-requester byte available.
REQ-005 SHALL have port req_data_i  input  16  requester k byte on bits [8k+7:8k].
REQ-006 SHALL have port req_lock_i  input  2  requester k keeps grant across consecutive bytes while high.
REQ-007 SHALL have port req_ready_o  output  2  one-cycle pulse: requester k's byte accepted.
REQ-008 SHALL have port tx_data_o  output  8  byte to transmitter.
REQ-009 SHALL have port tx_start_o  output  1  transmission request level.
REQ-010 SHALL have port tx_clear_i  input  1  transmitter pulse: request taken; tx_busy_i is high no later than this cycle.
REQ-011 SHALL have port tx_busy_i  input  1  transmitter shifting a frame.
REQ-012 SHALL have port grant_o  output  2  one-hot current owner, 2'b00 when unowned.
REQ-013 SHALL have port timeout_o  output  1  one-cycle pulse on start timeout.

Function
REQ-014 SHALL implement FSM states IDLE, START, DRAIN.
REQ-015 SHALL, in IDLE with owner k holding req_lock_i[k]=1: serve k if req_valid_i[k]=1, else wait in IDLE keeping grant_o; other requesters SHALL NOT be served.
REQ-016 SHALL, in IDLE with no locked owner, select among valid requesters round-robin: requester not served last has priority; after reset requester 0 has priority.
REQ-017 SHALL, on selecting k: pulse req_ready_o[k] that cycle, register req_data_i[8k+7:8k] into tx_data_o, set grant_o to one-hot k, update last-served to k, go to START with tx_start_o=1 on the next cycle.
REQ-018 SHALL accept at most one byte per frame; req_ready_o SHALL NOT pulse outside IDLE.
REQ-019 SHALL hold tx_start_o=1 and tx_data_o stable in START until tx_clear_i=1; that edge tx_start_o goes 0 and the FSM goes to DRAIN.
REQ-020 SHALL count START cycles in a 16-bit counter cleared on START entry; if the count reaches TIMEOUT_CYCLES with no tx_clear_i: tx_start_o<=0, timeout_o pulses 1 cycle, grant_o<=0, go to IDLE.
REQ-021 SHALL give tx_clear_i priority over timeout when both occur in the same cycle.
REQ-022 SHALL stay in DRAIN while tx_busy_i=1 and go to IDLE the cycle after tx_busy_i is sampled 0 (earliest: the cycle after DRAIN entry).
REQ-023 SHALL, on DRAIN->IDLE, keep grant_o if the owner's req_lock_i is 1, else set grant_o to 2'b00.
REQ-024 SHALL release a waiting lock when the owner drops req_lock_i: the next IDLE cycle follows REQ-016 with grant_o cleared.
REQ-025 SHALL tolerate req_valid_i changing at any time outside the accept cycle; unaccepted data is not retained.
REQ-026 SHALL minimum throughput: one byte per (frame time + 2) cycles per active requester.

Reset
REQ-027 SHALL, while wb_rst_i=1, asynchronously force: state IDLE, tx_start_o=0, tx_data_o=8'h00, req_ready_o=2'b00, grant_o=2'b00, timeout_o=0, counter=0, last-served=1 (requester 0 first).
REQ-028 SHALL, on reset mid-frame, drop tx_start_o immediately; the transmitter is reset by the same signal and no byte is re-sent.

Verification
REQ-029 SHALL cover: both valid, no lock, data 8'hA5/8'h3C, transmitter model clear 3 cycles after start, busy 20 cycles -> ready order 0,1,0,1; tx_data_o A5,3C,A5,3C.
REQ-030 SHALL cover: req1 lock=1 sends 8'h11,8'h22,8'h33 while req0 valid -> all three req1 bytes precede any req0 byte; grant_o=2'b10 throughout, including gaps with req_valid_i[1]=0.
REQ-031 SHALL cover: TIMEOUT_CYCLES=8, tx_clear_i never asserted -> tx_start_o high exactly 8 cycles, timeout_o single pulse, grant_o=0, next requester served.
REQ-032 SHALL cover: tx_clear_i in the same cycle the counter reaches TIMEOUT_CYCLES -> no timeout_o, FSM enters DRAIN.
REQ-033 SHALL cover: wb_rst_i asserted mid-START -> tx_start_o, grant_o, req_ready_o 0 in same cycle (async); after release requester 0 served first.
REQ-034 SHALL cover: tx_busy_i already 0 at DRAIN entry -> IDLE one cycle later; back-to-back requester served with REQ-026 spacing.
